sparc_mul_arb: RTL and testbench

Issue and sequencing controller directly upstream of the SPARC multiplier datapath. It arbitrates between EXU and SPU multiply requests and drives the datapath's `valid`, `spick` and `x2` inputs in the issue cycle. It tracks every issued operation through a fixed 5-cycle pipeline and signals completion to the owning requester. It also generates the ACCUM register controls (`acc_reg_enb`, `acc_reg_rst`, `acc_reg_shf`) for SPU accumulate, shift and clear requests.

---
 rtl/sparc_mul_arb_if.sv | 34 +++
 rtl/sparc_mul_arb.sv | 84 ++++++++
 tb/tb_sparc_mul_arb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sparc_mul_arb_if.sv
// Multiply issue/completion and ACCUM control bundle between the requesters and sparc_mul_arb.
// The master side drives requests and ACCUM pulses; the slave side drives acks, issue strobes and done.
interface sparc_mul_arb_if;
    logic ecl_mul_req_vld;
    logic spu_mul_req_vld;
    logic spu_mul_acc;
    logic spu_mul_x2;
    logic spu_mul_areg_shf;
    logic spu_mul_areg_rst;
    logic mul_ecl_ack;
    logic mul_spu_ack;
    logic valid;
    logic spick;
    logic x2;
    logic mul_ecl_done;
    logic mul_spu_done;
    logic acc_reg_enb;
    logic acc_reg_rst;
    logic acc_reg_shf;

    modport master (
        output ecl_mul_req_vld, spu_mul_req_vld, spu_mul_acc, spu_mul_x2,
               spu_mul_areg_shf, spu_mul_areg_rst,
        input  mul_ecl_ack, mul_spu_ack, valid, spick, x2,
               mul_ecl_done, mul_spu_done, acc_reg_enb, acc_reg_rst, acc_reg_shf
    );

    modport slave (
        input  ecl_mul_req_vld, spu_mul_req_vld, spu_mul_acc, spu_mul_x2,
               spu_mul_areg_shf, spu_mul_areg_rst,
        output mul_ecl_ack, mul_spu_ack, valid, spick, x2,
               mul_ecl_done, mul_spu_done, acc_reg_enb, acc_reg_rst, acc_reg_shf
    );
endinterface

// File: rtl/sparc_mul_arb.sv
// EXU/SPU multiply arbiter with LAT-cycle completion tracking and ACCUM control.
// Zero-cycle request-to-ack; requests are level and wait until acked; done fires LAT cycles after issue.
module sparc_mul_arb #(
    parameter int unsigned LAT = 5
) (
    input  logic           rclk,
    input  logic           rst,
    sparc_mul_arb_if.slave bus
);

    logic           last_spu;
    logic [LAT-1:0] pipe_vld;
    logic [LAT-1:0] pipe_spu;
    logic [LAT-1:0] pipe_acc;
    logic           shf_pend;
    logic           rst_pend;
    logic           shf_pend_nxt;
    logic           rst_pend_nxt;

    logic ecl_win;
    logic spu_win;
    logic issue;
    logic acc_done;
    logic shf_eff;
    logic rst_eff;

    // On a tie the requester that did not win last time takes the slot.
    assign ecl_win = ~rst & bus.ecl_mul_req_vld & (~bus.spu_mul_req_vld | last_spu);
    assign spu_win = ~rst & bus.spu_mul_req_vld & (~bus.ecl_mul_req_vld | ~last_spu);
    assign issue   = ecl_win | spu_win;

    assign bus.mul_ecl_ack  = ecl_win;
    assign bus.mul_spu_ack  = spu_win;
    assign bus.valid        = issue;
    assign bus.spick        = spu_win;
    assign bus.x2           = bus.spu_mul_x2 & spu_win;

    assign bus.mul_ecl_done = pipe_vld[LAT-1] & ~pipe_spu[LAT-1];
    assign bus.mul_spu_done = pipe_vld[LAT-1] & pipe_spu[LAT-1];
    assign acc_done         = bus.mul_spu_done & pipe_acc[LAT-1];

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            last_spu <= 1'b1;
            pipe_vld <= '0;
            pipe_spu <= '0;
            pipe_acc <= '0;
            shf_pend <= 1'b0;
            rst_pend <= 1'b0;
        end else begin
            if (issue) begin
                last_spu <= spu_win;
            end
            pipe_vld <= {pipe_vld[LAT-2:0], issue};
            pipe_spu <= {pipe_spu[LAT-2:0], spu_win};
            pipe_acc <= {pipe_acc[LAT-2:0], bus.spu_mul_acc & spu_win};
            shf_pend <= shf_pend_nxt;
            rst_pend <= rst_pend_nxt;
        end
    end

    // An accumulate load owns the ACCUM port; shift/clear wait for a free cycle.
    always_comb begin
        shf_eff          = shf_pend | (~rst & bus.spu_mul_areg_shf);
        rst_eff          = rst_pend | (~rst & bus.spu_mul_areg_rst);
        shf_pend_nxt     = shf_eff;
        rst_pend_nxt     = rst_eff;
        bus.acc_reg_enb  = 1'b0;
        bus.acc_reg_rst  = 1'b0;
        bus.acc_reg_shf  = 1'b0;
        if (acc_done) begin
            bus.acc_reg_enb = 1'b1;
        end else if (rst_eff) begin
            bus.acc_reg_rst = 1'b1;
            rst_pend_nxt    = 1'b0;
            shf_pend_nxt    = 1'b0;
        end else if (shf_eff) begin
            bus.acc_reg_enb = 1'b1;
            bus.acc_reg_shf = 1'b1;
            shf_pend_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_sparc_mul_arb.sv
// Randomized scoreboard bench for sparc_mul_arb: issue checked at drive time, completions and ACCUM
// controls checked by a separate monitor against a queue of expected results.
module tb_sparc_mul_arb;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    always #5 rclk = ~rclk;

    sparc_mul_arb_if bus ();

    sparc_mul_arb #(.LAT(5)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        int due;
        bit spu;
        bit acc;
    } op_t;

    op_t sbq[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  in_rst = 1'b1;
    bit  m_last_spu = 1'b1;
    bit  m_shf_p = 1'b0;
    bit  m_rst_p = 1'b0;

    bit  m_ed, m_es, m_ad, m_enb, m_rs, m_sh;
    op_t m_op;

    initial forever begin
        @(posedge rclk);
        cyc++;
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and check the issue-cycle outputs against the arbitration rules.
    task automatic step(input bit e, input bit s, input bit a, input bit x,
                        input bit sh, input bit rp, output bit ge, output bit gs);
        op_t o;
        @(negedge rclk);
        bus.ecl_mul_req_vld  = e;
        bus.spu_mul_req_vld  = s;
        bus.spu_mul_acc      = a;
        bus.spu_mul_x2       = x;
        bus.spu_mul_areg_shf = sh;
        bus.spu_mul_areg_rst = rp;
        #1;
        ge = e && (!s || m_last_spu);
        gs = s && (!e || !m_last_spu);
        chk("ecl_ack", bus.mul_ecl_ack, ge);
        chk("spu_ack", bus.mul_spu_ack, gs);
        chk("valid",   bus.valid,       ge || gs);
        chk("spick",   bus.spick,       gs);
        chk("x2",      bus.x2,          gs && x);
        if (ge || gs) begin
            o.due = cyc + 5;
            o.spu = gs;
            o.acc = gs && a;
            sbq.push_back(o);
            m_last_spu = gs;
        end
    endtask

    task automatic idle(input int n);
        bit ge, gs;
        repeat (n) step(0, 0, 0, 0, 0, 0, ge, gs);
    endtask

    // Async reset mid-cycle with both requests held, so zero outputs are meaningful.
    task automatic do_reset(input int hold);
        @(posedge rclk);
        #2;
        bus.ecl_mul_req_vld  = 1'b1;
        bus.spu_mul_req_vld  = 1'b1;
        bus.spu_mul_x2       = 1'b1;
        bus.spu_mul_areg_shf = 1'b0;
        bus.spu_mul_areg_rst = 1'b0;
        rst    = 1'b1;
        in_rst = 1'b1;
        sbq.delete();
        m_last_spu = 1'b1;
        m_shf_p    = 1'b0;
        m_rst_p    = 1'b0;
        #1;
        chk("rst_ecl_ack", bus.mul_ecl_ack, 1'b0);
        chk("rst_spu_ack", bus.mul_spu_ack, 1'b0);
        chk("rst_valid",   bus.valid,       1'b0);
        chk("rst_spick",   bus.spick,       1'b0);
        chk("rst_x2",      bus.x2,          1'b0);
        repeat (hold) @(posedge rclk);
        #2;
        rst    = 1'b0;
        in_rst = 1'b0;
    endtask

    // Monitor: completions and ACCUM controls, sampled mid-cycle after the driver has settled.
    initial forever begin
        @(negedge rclk);
        #2;
        if (in_rst) begin
            chk("rst_ecl_done", bus.mul_ecl_done, 1'b0);
            chk("rst_spu_done", bus.mul_spu_done, 1'b0);
            chk("rst_acc_enb",  bus.acc_reg_enb,  1'b0);
            chk("rst_acc_rst",  bus.acc_reg_rst,  1'b0);
            chk("rst_acc_shf",  bus.acc_reg_shf,  1'b0);
        end else begin
            m_ed = 1'b0;
            m_es = 1'b0;
            m_ad = 1'b0;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                m_op = sbq.pop_front();
                m_ed = !m_op.spu;
                m_es = m_op.spu;
                m_ad = m_op.spu && m_op.acc;
            end
            chk("ecl_done", bus.mul_ecl_done, m_ed);
            chk("spu_done", bus.mul_spu_done, m_es);
            // Shift/clear requests wait for a cycle with no accumulate; clear swallows a shift.
            m_shf_p = m_shf_p || bus.spu_mul_areg_shf;
            m_rst_p = m_rst_p || bus.spu_mul_areg_rst;
            m_enb = 1'b0;
            m_rs  = 1'b0;
            m_sh  = 1'b0;
            if (m_ad) begin
                m_enb = 1'b1;
            end else if (m_rst_p) begin
                m_rs    = 1'b1;
                m_rst_p = 1'b0;
                m_shf_p = 1'b0;
            end else if (m_shf_p) begin
                m_enb   = 1'b1;
                m_sh    = 1'b1;
                m_shf_p = 1'b0;
            end
            chk("acc_enb", bus.acc_reg_enb, m_enb);
            chk("acc_rst", bus.acc_reg_rst, m_rs);
            chk("acc_shf", bus.acc_reg_shf, m_sh);
        end
    end

    initial begin
        bit ge, gs, er, sr;
        bus.ecl_mul_req_vld  = 1'b0;
        bus.spu_mul_req_vld  = 1'b0;
        bus.spu_mul_acc      = 1'b0;
        bus.spu_mul_x2       = 1'b0;
        bus.spu_mul_areg_shf = 1'b0;
        bus.spu_mul_areg_rst = 1'b0;
        do_reset(2);

        // Tie held after reset: EXU first, then alternating.
        repeat (4) step(1, 1, 0, 0, 0, 0, ge, gs);
        idle(6);
        step(1, 0, 0, 0, 0, 0, ge, gs);
        idle(6);

        // Accumulating x2 SPU op, then a shift landing on its completion cycle.
        step(0, 1, 1, 1, 0, 0, ge, gs);
        idle(4);
        step(0, 0, 0, 0, 1, 0, ge, gs);
        idle(3);

        // Clear and shift together on an idle cycle.
        step(0, 0, 0, 0, 1, 1, ge, gs);
        idle(3);

        // In-flight ops dropped by reset; request after release issues at once.
        repeat (3) step(1, 0, 0, 0, 0, 0, ge, gs);
        do_reset(2);
        step(1, 0, 0, 0, 0, 0, ge, gs);
        idle(7);

        er = 1'b0;
        sr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!er && $urandom_range(2) == 0) er = 1'b1;
            if (!sr && $urandom_range(2) == 0) sr = 1'b1;
            step(er, sr, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 $urandom_range(6) == 0, $urandom_range(15) == 0, ge, gs);
            if (ge) er = 1'b0;
            if (gs) sr = 1'b0;
            if ($urandom_range(599) == 0) begin
                do_reset(1 + $urandom_range(2));
            end
        end

        idle(8);
        chk("sb_drained", sbq.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
